// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: LEGv8 instruction-fetch stage.
// Keeps the PC, issues one word fetch at a time to instruction memory and
// buffers {pc, instr} pairs for decode. A taken branch from execute redirects
// the PC to branch_pc + (imm << 2) and flushes all wrong-path work.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both 1
// at the rising clock edge. imem_req_valid and imem_addr depend only on
// registered state, never on imem_req_ready. Once imem_req_valid is raised,
// it stays high with a constant imem_addr until accepted, unless a redirect
// occurs. imem_rsp_valid is a one-cycle, in-order pulse with no ready.
// if_valid/if_pc/if_instr come straight from registers. Decode pops the head
// on if_valid && if_ready.
module pc_fetch_unit #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [63:0]       redirect_imm,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [1:0]        dbg_state
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_armed;
    logic              r_drop;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_q_pc    [QDEPTH];
    logic [31:0]       r_q_instr [QDEPTH];

    logic [ADDR_W-1:0] w_q_pc_nxt    [QDEPTH];
    logic [31:0]       w_q_instr_nxt [QDEPTH];
    logic [CW-1:0]     w_count_nxt;
    logic [CW-1:0]     w_wr_idx;
    logic [ADDR_W-1:0] w_pc_tgt;
    logic              w_space;
    logic              w_req_fire;
    logic              w_rsp_take;
    logic              w_push;
    logic              w_pop;
    logic              w_unused_imm;

    // Branch target: offset is in words, so shift left by two; wraps modulo 2^ADDR_W.
    assign w_pc_tgt     = redirect_pc + {redirect_imm[ADDR_W-3:0], 2'b00};
    // Upper immediate bits beyond ADDR_W shift out of the target.
    assign w_unused_imm = ^redirect_imm[63:ADDR_W-2];

    assign w_space    = (r_count < QD);
    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_take = (r_state == S_WAIT) && imem_rsp_valid;
    // A redirect kills both the arriving response and any same-cycle pop.
    assign w_push     = w_rsp_take && !r_drop && !redirect_valid;
    assign w_pop      = if_valid && if_ready && !redirect_valid;
    assign w_wr_idx   = r_count - CW'(w_pop);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect overrides the normal transitions.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end else if (!redirect_valid && !w_space) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_WAIT: begin
                if (w_rsp_take) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid || w_space) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // Output logic: request only while in REQ with a free queue slot reserved.
    always_comb begin
        imem_req_valid = r_armed && (r_state == S_REQ) && w_space;
        imem_addr      = r_pc;
        dbg_state      = r_state;
    end

    // Request outputs stay low while reset is held and for the first cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Drop flag marks the one outstanding response as wrong-path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else if (redirect_valid) begin
            if (r_state == S_WAIT) begin
                r_drop <= !imem_rsp_valid;
            end else if (w_req_fire) begin
                r_drop <= 1'b1;
            end else begin
                r_drop <= 1'b0;
            end
        end else if (w_rsp_take) begin
            r_drop <= 1'b0;
        end
    end

    // PC advances on a kept response and jumps on a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_pc_tgt;
        end else if (w_push) begin
            r_pc <= r_pc + ADDR_W'(4);
        end
    end

    // Address of the request in flight, paired with its returning data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_req_fire) begin
            r_fetch_pc <= r_pc;
        end
    end

    // Queue next-state: shift on pop, write at the first free slot, clear on flush.
    always_comb begin
        for (int i = 0; i < int'(QDEPTH); i++) begin
            w_q_pc_nxt[i]    = r_q_pc[i];
            w_q_instr_nxt[i] = r_q_instr[i];
        end
        if (w_pop) begin
            for (int i = 0; i < int'(QDEPTH) - 1; i++) begin
                w_q_pc_nxt[i]    = r_q_pc[i+1];
                w_q_instr_nxt[i] = r_q_instr[i+1];
            end
            w_q_pc_nxt[QDEPTH-1]    = '0;
            w_q_instr_nxt[QDEPTH-1] = '0;
        end
        if (w_push) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                if (i == int'(w_wr_idx)) begin
                    w_q_pc_nxt[i]    = r_fetch_pc;
                    w_q_instr_nxt[i] = imem_rsp_data;
                end
            end
        end
        if (redirect_valid) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                w_q_pc_nxt[i]    = '0;
                w_q_instr_nxt[i] = '0;
            end
        end
    end

    // Queue occupancy: push and pop together leave it unchanged.
    always_comb begin
        if (redirect_valid) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage registers; unused slots hold zero so an empty head reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                r_q_pc[i]    <= w_q_pc_nxt[i];
                r_q_instr[i] <= w_q_instr_nxt[i];
            end
        end
    end

    assign if_valid = (r_count != '0);
    assign if_pc    = r_q_pc[0];
    assign if_instr = r_q_instr[0];

endmodule
